bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Bus-side initiator for the shared 16-bit register bus.
- Generates the per-register LDBUS (read-out) and WR (write-in) strobes that the bus registers consume. Sequences one register-to-register move, or one immediate-to-register load, per request.
- Captures the value that crossed the bus.
- Sits between the processor control unit and the bank of bus registers.

Parameters:
- NREG, 8, number of bus registers controlled (one LDBUS and one WR line each)
- SELW, 3, width of register select fields (ceil(log2(NREG)))
- DW, 16, bus data width

Ports:
- clk  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-low (RST==0 at posedge resets)
- REQ  in  1  transfer request; sampled only in IDLE
- IMM_EN  in  1  1 = immediate load (IMM to DST_SEL); 0 = register move (SRC_SEL to DST_SEL)
- SRC_SEL  in  SELW  source register index
- DST_SEL  in  SELW  destination register index
- IMM  in  DW  immediate value
- BUS_IN  in  DW  shared bus as seen by the controller
- BUS_OUT  out  DW  value the controller drives on the bus in immediate mode
- BUS_OE  out  1  controller bus-drive enable
- LDBUS  out  NREG  one-hot read-out strobes to registers
- WR  out  NREG  one-hot write strobes to registers
- BUSY  out  1  high from request acceptance until DONE
- DONE  out  1  one-cycle pulse when the transfer completes
- ERR  out  1  one-cycle pulse when a request is rejected
- XDATA  out  DW  last value captured from the bus

Behaviour:
- Reset (RST==0 at posedge): state=IDLE; LDBUS=0; WR=0; BUS_OE=0; BUS_OUT=0; BUSY=0; DONE=0; ERR=0; XDATA=0.
  - Reset overrides any state mid-transfer; all strobes drop in the same cycle.
- Request acceptance in IDLE with REQ=1:
  - Latch IMM_EN, SRC_SEL, DST_SEL and IMM into internal registers.
  - Inputs may change after acceptance with no effect on the transfer.
- Rejection:
  - Reject when any used select is >= NREG, or when IMM_EN=0 and SRC_SEL==DST_SEL.
  - On rejection: ERR pulses for 1 cycle, state stays IDLE, no strobes, XDATA unchanged.
- FSM states: IDLE, DRIVE, WRITE, DONE.
  - IDLE -> DRIVE on a valid REQ.
  - DRIVE: register mode asserts LDBUS[src]=1; immediate mode asserts BUS_OE=1 and BUS_OUT=IMM, with LDBUS=0. The bus settles during this cycle. XDATA is not loaded. -> WRITE.
  - WRITE: keep the same bus driver asserted. Assert WR[dst]=1. At the end of the cycle, XDATA<=BUS_IN; the destination register captures the bus on the same edge. -> DONE.
  - DONE: all strobes 0, BUS_OE=0, DONE=1. -> IDLE.
- Latency: accept edge to DONE high is 3 cycles. BUSY is high in DRIVE, WRITE and DONE.
  - Back-to-back: a REQ held high is accepted again in the IDLE cycle after DONE. Minimum period is 4 cycles per transfer.
- Bus-contention rules:
  - At most one LDBUS bit is high at any time.
  - LDBUS is never high while BUS_OE is high.
  - At most one WR bit is high at any time.
  - WR is never asserted in the same cycle its register's LDBUS is asserted.
- All outputs are registered (driven from state registers, no combinational path from inputs).
- REQ is ignored while BUSY=1.

Decomposition:
- Shared package bus_pkg holds:
  - state enum (IDLE, DRIVE, WRITE, DONE)
  - DW constant
  - function onehot(sel) returning NREG-wide one-hot
- Sub-module onehot_dec (SELW -> NREG decoder with valid flag), instantiated twice: once for LDBUS, once for WR.

Test Plan:
- Register move: R2 preloaded 16'hA5C3; REQ, IMM_EN=0, SRC=2, DST=5 -> LDBUS=8'h04 for 2 cycles; WR=8'h20 in the 2nd cycle; DONE 3 cycles after accept; XDATA=16'hA5C3; R5=16'hA5C3.
- Immediate load: IMM=16'h1234, DST=0 -> BUS_OE high 2 cycles; LDBUS=0 throughout; WR=8'h01 in WRITE; XDATA=16'h1234.
- Rejection: SRC=DST=3 with IMM_EN=0 -> ERR pulse 1 cycle; BUSY=0; no strobes; XDATA unchanged.
- Reset mid-transfer: RST=0 during WRITE -> next edge LDBUS=0, WR=0, BUS_OE=0, state IDLE, XDATA=0; destination register not required to update.
- Back-to-back and ignored REQ: REQ held high with changing SRC during BUSY -> the latched SRC is used; second transfer accepted exactly 1 cycle after DONE; contention checker (one-hot/exclusion assertions) passes over 1000 random transfers.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the register-bus initiator.
// Revision    : 1.0
// ============================================================================
package bus_pkg;

    localparam int C_NREG = 8;
    localparam int C_SELW = 3;
    localparam int C_DW   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [C_NREG-1:0] onehot(input logic [C_SELW-1:0] sel);
        logic [C_NREG-1:0] v;
        v = '0;
        for (int i = 0; i < C_NREG; i++) begin
            if (sel == C_SELW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Register-select to one-hot strobe decoder with range flag.
// Revision    : 1.0
// ============================================================================
module onehot_dec
    import bus_pkg::*;
#(
    parameter int N    = C_NREG,
    parameter int SELW = C_SELW
) (
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    oh,
    output logic            valid
);

    generate
        if (N == C_NREG && SELW == C_SELW) begin : g_pkg
            assign oh = onehot(sel);
        end else begin : g_generic
            for (genvar i = 0; i < N; i++) begin : g_bit
                assign oh[i] = (sel == SELW'(i));
            end
        end
    endgenerate

    // Out-of-range selects would address a register that does not exist.
    assign valid = (int'(sel) < N);

endmodule
`default_nettype wire

// File: rtl/bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_xfer_ctrl
// Description : Sequences one register move or immediate load per request
//               on the shared register bus; all outputs registered.
// Revision    : 1.0
// ============================================================================
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int NREG = C_NREG,
    parameter int SELW = C_SELW,
    parameter int DW   = C_DW
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            REQ,
    input  logic            IMM_EN,
    input  logic [SELW-1:0] SRC_SEL,
    input  logic [SELW-1:0] DST_SEL,
    input  logic [DW-1:0]   IMM,
    input  logic [DW-1:0]   BUS_IN,
    output logic [DW-1:0]   BUS_OUT,
    output logic            BUS_OE,
    output logic [NREG-1:0] LDBUS,
    output logic [NREG-1:0] WR,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic [DW-1:0]   XDATA
);

    state_t          r_state;
    state_t          w_next_state;

    logic            r_imm_en;
    logic [SELW-1:0] r_src;
    logic [SELW-1:0] r_dst;
    logic [DW-1:0]   r_imm;

    logic [NREG-1:0] r_ldbus;
    logic [NREG-1:0] r_wr;
    logic            r_oe;
    logic [DW-1:0]   r_bus_out;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [DW-1:0]   r_xdata;

    logic [NREG-1:0] w_ldbus_nxt;
    logic [NREG-1:0] w_wr_nxt;
    logic            w_oe_nxt;
    logic [DW-1:0]   w_bus_out_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;

    logic            w_idle;
    logic            w_imm_en;
    logic [SELW-1:0] w_src_sel;
    logic [SELW-1:0] w_dst_sel;
    logic [DW-1:0]   w_imm;
    logic [NREG-1:0] w_src_oh;
    logic [NREG-1:0] w_dst_oh;
    logic            w_src_ok;
    logic            w_dst_ok;
    logic            w_accept;
    logic            w_reject;

    // In IDLE the live inputs are decoded so strobes can register on the
    // accept edge; afterwards the latched copies keep the transfer stable.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_imm_en  = w_idle ? IMM_EN  : r_imm_en;
    assign w_src_sel = w_idle ? SRC_SEL : r_src;
    assign w_dst_sel = w_idle ? DST_SEL : r_dst;
    assign w_imm     = w_idle ? IMM     : r_imm;

    onehot_dec #(
        .N    (NREG),
        .SELW (SELW)
    ) u_src_dec (
        .sel   (w_src_sel),
        .oh    (w_src_oh),
        .valid (w_src_ok)
    );

    onehot_dec #(
        .N    (NREG),
        .SELW (SELW)
    ) u_dst_dec (
        .sel   (w_dst_sel),
        .oh    (w_dst_oh),
        .valid (w_dst_ok)
    );

    assign w_accept = w_idle && REQ && w_dst_ok &&
                      (IMM_EN || (w_src_ok && (SRC_SEL != DST_SEL)));
    assign w_reject = w_idle && REQ && !w_accept;

    always_comb begin
        w_next_state  = r_state;
        w_ldbus_nxt   = '0;
        w_wr_nxt      = '0;
        w_oe_nxt      = 1'b0;
        w_bus_out_nxt = '0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_DRIVE;
                    w_busy_nxt   = 1'b1;
                    if (w_imm_en) begin
                        w_oe_nxt      = 1'b1;
                        w_bus_out_nxt = w_imm;
                    end else begin
                        w_ldbus_nxt = w_src_oh;
                    end
                end else if (w_reject) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_DRIVE: begin
                w_next_state = ST_WRITE;
                w_busy_nxt   = 1'b1;
                w_wr_nxt     = w_dst_oh;
                if (w_imm_en) begin
                    w_oe_nxt      = 1'b1;
                    w_bus_out_nxt = w_imm;
                end else begin
                    w_ldbus_nxt = w_src_oh;
                end
            end
            ST_WRITE: begin
                w_next_state = ST_DONE;
                w_busy_nxt   = 1'b1;
                w_done_nxt   = 1'b1;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state   <= ST_IDLE;
            r_imm_en  <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_imm     <= '0;
            r_ldbus   <= '0;
            r_wr      <= '0;
            r_oe      <= 1'b0;
            r_bus_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_xdata   <= '0;
        end else begin
            r_state   <= w_next_state;
            if (w_accept) begin
                r_imm_en <= IMM_EN;
                r_src    <= SRC_SEL;
                r_dst    <= DST_SEL;
                r_imm    <= IMM;
            end
            r_ldbus   <= w_ldbus_nxt;
            r_wr      <= w_wr_nxt;
            r_oe      <= w_oe_nxt;
            r_bus_out <= w_bus_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            // Same edge on which the destination register captures the bus.
            if (r_state == ST_WRITE) begin
                r_xdata <= BUS_IN;
            end
        end
    end

    assign BUS_OUT = r_bus_out;
    assign BUS_OE  = r_oe;
    assign LDBUS   = r_ldbus;
    assign WR      = r_wr;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ERR     = r_err;
    assign XDATA   = r_xdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_xfer_ctrl
// Description : Directed and randomised self-checking bench for bus_xfer_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_bus_xfer_ctrl;

    logic        clk;
    logic        RST;
    logic        REQ;
    logic        IMM_EN;
    logic [2:0]  SRC_SEL;
    logic [2:0]  DST_SEL;
    logic [15:0] IMM;
    logic [15:0] BUS_IN;
    logic [15:0] BUS_OUT;
    logic        BUS_OE;
    logic [7:0]  LDBUS;
    logic [7:0]  WR;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [15:0] XDATA;

    logic [15:0] bank [0:7];
    logic [15:0] mdl  [0:7];
    logic        pl_en;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;
    logic [15:0] ld_val;

    int n_assert;
    int n_fail;

    bus_xfer_ctrl dut (
        .clk     (clk),
        .RST     (RST),
        .REQ     (REQ),
        .IMM_EN  (IMM_EN),
        .SRC_SEL (SRC_SEL),
        .DST_SEL (DST_SEL),
        .IMM     (IMM),
        .BUS_IN  (BUS_IN),
        .BUS_OUT (BUS_OUT),
        .BUS_OE  (BUS_OE),
        .LDBUS   (LDBUS),
        .WR      (WR),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .XDATA   (XDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank on the shared bus.
    always_comb begin
        ld_val = '0;
        for (int i = 0; i < 8; i++) begin
            if (LDBUS[i]) ld_val = ld_val | bank[i];
        end
        BUS_IN = BUS_OE ? BUS_OUT : ld_val;
    end

    always @(posedge clk) begin
        if (pl_en) begin
            bank[pl_idx] <= pl_val;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (WR[i]) bank[i] <= BUS_IN;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic contention();
        chk("ldbus_onehot0", 32'($onehot0(LDBUS)), 1);
        chk("ldbus_vs_oe",   32'((|LDBUS) && BUS_OE), 0);
        chk("wr_onehot0",    32'($onehot0(WR)), 1);
        chk("wr_vs_ldbus",   32'(WR & LDBUS), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        contention();
    endtask

    task automatic xfer(input logic imm, input logic [2:0] src, input logic [2:0] dst,
                        input logic [15:0] val);
        logic [15:0] exp;
        exp = imm ? val : mdl[src];
        REQ = 1'b1; IMM_EN = imm; SRC_SEL = src; DST_SEL = dst; IMM = val;
        tick();
        REQ = 1'b0; IMM_EN = 1'($urandom); SRC_SEL = 3'($urandom);
        DST_SEL = 3'($urandom); IMM = 16'($urandom);
        chk("x_busy", 32'(BUSY), 1);
        tick();
        tick();
        chk("x_done",  32'(DONE), 1);
        chk("x_xdata", 32'(XDATA), 32'(exp));
        chk("x_reg",   32'(bank[dst]), 32'(exp));
        mdl[dst] = exp;
        tick();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        RST = 1'b0; REQ = 1'b0; IMM_EN = 1'b0; SRC_SEL = '0; DST_SEL = '0; IMM = '0;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;

        // Reset with bank preload
        for (int i = 0; i < 8; i++) begin
            pl_en = 1'b1; pl_idx = 3'(i);
            pl_val = (i == 2) ? 16'hA5C3 : 16'(16'h1000 + i);
            tick();
        end
        pl_en = 1'b0;
        chk("rst_ldbus", 32'(LDBUS), 0);
        chk("rst_wr",    32'(WR), 0);
        chk("rst_oe",    32'(BUS_OE), 0);
        chk("rst_busout",32'(BUS_OUT), 0);
        chk("rst_busy",  32'(BUSY), 0);
        chk("rst_done",  32'(DONE), 0);
        chk("rst_err",   32'(ERR), 0);
        chk("rst_xdata", 32'(XDATA), 0);
        RST = 1'b1;
        tick();

        // Register move R2 -> R5
        REQ = 1'b1; IMM_EN = 1'b0; SRC_SEL = 3'd2; DST_SEL = 3'd5;
        tick();
        REQ = 1'b0; SRC_SEL = 3'd7;
        chk("mv_drive_ldbus", 32'(LDBUS), 'h04);
        chk("mv_drive_wr",    32'(WR), 0);
        chk("mv_drive_busy",  32'(BUSY), 1);
        chk("mv_drive_oe",    32'(BUS_OE), 0);
        tick();
        chk("mv_write_ldbus", 32'(LDBUS), 'h04);
        chk("mv_write_wr",    32'(WR), 'h20);
        chk("mv_write_done",  32'(DONE), 0);
        tick();
        chk("mv_done",        32'(DONE), 1);
        chk("mv_done_busy",   32'(BUSY), 1);
        chk("mv_done_ldbus",  32'(LDBUS), 0);
        chk("mv_done_wr",     32'(WR), 0);
        chk("mv_xdata",       32'(XDATA), 'hA5C3);
        chk("mv_r5",          32'(bank[5]), 'hA5C3);
        tick();
        chk("mv_idle_done",   32'(DONE), 0);
        chk("mv_idle_busy",   32'(BUSY), 0);

        // Immediate load 0x1234 -> R0
        REQ = 1'b1; IMM_EN = 1'b1; IMM = 16'h1234; SRC_SEL = 3'd0; DST_SEL = 3'd0;
        tick();
        REQ = 1'b0; IMM = 16'hFFFF;
        chk("im_drive_oe",    32'(BUS_OE), 1);
        chk("im_drive_out",   32'(BUS_OUT), 'h1234);
        chk("im_drive_ldbus", 32'(LDBUS), 0);
        tick();
        chk("im_write_oe",    32'(BUS_OE), 1);
        chk("im_write_out",   32'(BUS_OUT), 'h1234);
        chk("im_write_wr",    32'(WR), 'h01);
        chk("im_write_ldbus", 32'(LDBUS), 0);
        tick();
        chk("im_done",        32'(DONE), 1);
        chk("im_done_oe",     32'(BUS_OE), 0);
        chk("im_xdata",       32'(XDATA), 'h1234);
        chk("im_r0",          32'(bank[0]), 'h1234);
        tick();

        // Rejection: register move onto itself
        REQ = 1'b1; IMM_EN = 1'b0; SRC_SEL = 3'd3; DST_SEL = 3'd3;
        tick();
        REQ = 1'b0;
        chk("rej_err",   32'(ERR), 1);
        chk("rej_busy",  32'(BUSY), 0);
        chk("rej_ldbus", 32'(LDBUS), 0);
        chk("rej_wr",    32'(WR), 0);
        tick();
        chk("rej_err_pulse", 32'(ERR), 0);
        chk("rej_busy2",     32'(BUSY), 0);
        chk("rej_xdata",     32'(XDATA), 'h1234);

        // Reset during WRITE
        REQ = 1'b1; IMM_EN = 1'b0; SRC_SEL = 3'd5; DST_SEL = 3'd1;
        tick();
        REQ = 1'b0;
        tick();
        chk("mr_write_wr", 32'(WR), 'h02);
        RST = 1'b0;
        tick();
        chk("mr_ldbus", 32'(LDBUS), 0);
        chk("mr_wr",    32'(WR), 0);
        chk("mr_oe",    32'(BUS_OE), 0);
        chk("mr_busy",  32'(BUSY), 0);
        chk("mr_done",  32'(DONE), 0);
        chk("mr_xdata", 32'(XDATA), 0);
        RST = 1'b1;
        tick();
        chk("mr_idle_done", 32'(DONE), 0);

        // Back-to-back with REQ held and inputs changing while busy
        REQ = 1'b1; IMM_EN = 1'b0; SRC_SEL = 3'd5; DST_SEL = 3'd6;
        tick();
        SRC_SEL = 3'd0; DST_SEL = 3'd7;
        chk("bb1_drive_ldbus", 32'(LDBUS), 'h20);
        tick();
        chk("bb1_write_ldbus", 32'(LDBUS), 'h20);
        chk("bb1_write_wr",    32'(WR), 'h40);
        tick();
        chk("bb1_done",  32'(DONE), 1);
        chk("bb1_xdata", 32'(XDATA), 'hA5C3);
        chk("bb1_r6",    32'(bank[6]), 'hA5C3);
        tick();
        chk("bb_idle_busy",  32'(BUSY), 0);
        chk("bb_idle_ldbus", 32'(LDBUS), 0);
        tick();
        REQ = 1'b0;
        chk("bb2_drive_ldbus", 32'(LDBUS), 'h01);
        chk("bb2_drive_busy",  32'(BUSY), 1);
        tick();
        chk("bb2_write_wr", 32'(WR), 'h80);
        tick();
        chk("bb2_done",  32'(DONE), 1);
        chk("bb2_xdata", 32'(XDATA), 'h1234);
        chk("bb2_r7",    32'(bank[7]), 'h1234);
        tick();

        // Load every register with a known value, then random transfers
        for (int i = 0; i < 8; i++) begin
            xfer(1'b1, 3'd0, 3'(i), 16'(16'h5A00 + (i * 16'h0111)));
        end
        for (int t = 0; t < 1000; t++) begin
            logic        r_imm;
            logic [2:0]  r_s;
            logic [2:0]  r_d;
            r_imm = 1'($urandom);
            r_s   = 3'($urandom);
            r_d   = 3'($urandom);
            if (!r_imm && (r_s == r_d)) begin
                REQ = 1'b1; IMM_EN = 1'b0; SRC_SEL = r_s; DST_SEL = r_d;
                tick();
                REQ = 1'b0;
                chk("rnd_rej_err",  32'(ERR), 1);
                chk("rnd_rej_busy", 32'(BUSY), 0);
                tick();
            end else begin
                xfer(r_imm, r_s, r_d, 16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
